// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus registers, a byte FIFO and a serialiser
// with a programmable baud divisor. Reads are combinational, writes land on the rising edge.
module mmio_uart_tx #(
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] RESET_DIV = 16'd650
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [29:0] ADDR,
    input  logic [31:0] DATAI,
    output logic [31:0] DATAO,
    input  logic        CE,
    input  logic [3:0]  WSTB,
    output logic        TXD,
    output logic        IRQ
);

    localparam int                 DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   LEVEL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LEVEL_ZERO = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ZERO   = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]         fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               ovf_r;
    logic               tx_en_r;
    logic               ie_r;
    logic [15:0]        baud_div_r;

    state_t             state_r;
    logic [15:0]        cnt_r;
    logic [2:0]         bit_idx_r;
    logic [7:0]         shift_r;
    logic               txd_r;

    logic [1:0]         sel_s;
    logic               wr_txdata_s;
    logic               wr_ctrl_s;
    logic               wr_baud_lo_s;
    logic               wr_baud_hi_s;
    logic               full_s;
    logic               empty_s;
    logic               busy_s;
    logic               bit_end_s;
    logic               push_s;
    logic               pop_s;
    logic               unused_s;

    assign sel_s        = ADDR[1:0];
    assign wr_txdata_s  = CE & (sel_s == 2'd0) & WSTB[0];
    assign wr_ctrl_s    = CE & (sel_s == 2'd2) & WSTB[0];
    assign wr_baud_lo_s = CE & (sel_s == 2'd3) & WSTB[0];
    assign wr_baud_hi_s = CE & (sel_s == 2'd3) & WSTB[1];

    assign full_s    = (level_r == LEVEL_FULL);
    assign empty_s   = (level_r == LEVEL_ZERO);
    assign busy_s    = (state_r != ST_IDLE);
    // Live divisor comparison: a lowered BAUDDIV ends an over-long bit at once.
    assign bit_end_s = (cnt_r >= baud_div_r);

    assign push_s = wr_txdata_s & ~full_s;
    assign pop_s  = tx_en_r & ~empty_s &
                    ((state_r == ST_IDLE) | ((state_r == ST_STOP) & bit_end_s));

    assign TXD = txd_r;
    assign IRQ = ie_r & empty_s & ~busy_s;

    assign unused_s = ^{ADDR[29:2], DATAI[31:16], WSTB[3:2]};

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= DATAI[7:0];
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, fill level and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LEVEL_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
            // A dropped push is flagged even when a pop frees a slot in the same cycle.
            if (wr_txdata_s & full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_ctrl_s & DATAI[1]) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Control and baud divisor registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_en_r    <= 1'b1;
            ie_r       <= 1'b0;
            baud_div_r <= RESET_DIV;
        end else begin
            if (wr_ctrl_s) begin
                tx_en_r <= DATAI[0];
                ie_r    <= DATAI[2];
            end else begin
                tx_en_r <= tx_en_r;
                ie_r    <= ie_r;
            end
            if (wr_baud_lo_s) begin
                baud_div_r[7:0] <= DATAI[7:0];
            end else begin
                baud_div_r[7:0] <= baud_div_r[7:0];
            end
            if (wr_baud_hi_s) begin
                baud_div_r[15:8] <= DATAI[15:8];
            end else begin
                baud_div_r[15:8] <= baud_div_r[15:8];
            end
        end
    end

    // Serialiser FSM: start bit, 8 data bits LSB first, one stop bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                    if (pop_s) begin
                        shift_r <= fifo_mem_r[rd_ptr_r];
                        state_r <= ST_START;
                        txd_r   <= 1'b0;
                    end else begin
                        txd_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= 16'd0;
                        bit_idx_r <= 3'd0;
                        txd_r     <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                        state_r   <= ST_DATA;
                    end else begin
                        cnt_r     <= cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            txd_r     <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        // Back-to-back frames: the next start bit follows the stop bit directly.
                        if (pop_s) begin
                            shift_r <= fifo_mem_r[rd_ptr_r];
                            state_r <= ST_START;
                            txd_r   <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 16'd0;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

    // Combinational register read mux.
    always_comb begin
        DATAO = 32'd0;
        case (sel_s)
            2'd0: DATAO = 32'd0;
            2'd1: DATAO = {{(23 - FIFO_AW){1'b0}}, level_r, 4'b0000,
                           ovf_r, busy_s, empty_s, full_s};
            2'd2: DATAO = {29'd0, ie_r, 1'b0, tx_en_r};
            2'd3: DATAO = {16'd0, baud_div_r};
            default: DATAO = 32'd0;
        endcase
    end

endmodule
